// File: rtl/mul_hazard_ctrl_pkg.sv
// Shared constants for the multiplier hazard controller: forwarding mux encodings
// and the states of the multiplier occupancy FSM.
package mul_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_EXMEM   = 2'd2;
  localparam logic [1:0] FWD_MEMWB   = 2'd1;
  localparam logic [1:0] FWD_REGFILE = 2'd0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mul_hazard_ctrl_mul_latency_ctr.sv
// Sequences the EX-stage occupancy of a multi-cycle MUL: start pulse, stall cycles,
// and a done pulse on the last cycle. Only state and counter are registered.
module mul_latency_ctr
  import mul_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 3
) (
  input  logic clk,
  input  logic arst_n,
  input  logic ex_is_mul,
  output logic mul_start,
  output logic mul_stall,
  output logic mul_done,
  output logic mul_busy
);

  localparam int CNT_W = $clog2(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // The start cycle is spent in IDLE, so BUSY covers the remaining MULT_CYCLES-1 cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_CYCLES - 2);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;

  // Occupancy FSM and remaining-cycle counter.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ex_is_mul) begin
            state_r <= ST_BUSY;
            cnt_r   <= CNT_LOAD;
          end else begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
          end
        end
        ST_BUSY: begin
          if (cnt_r != CNT_ZERO) begin
            state_r <= ST_BUSY;
            cnt_r   <= cnt_r - CNT_ONE;
          end else begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  // Decode the sequencing outputs from state, counter and the incoming MUL flag.
  always_comb begin
    mul_start = 1'b0;
    mul_stall = 1'b0;
    mul_done  = 1'b0;
    mul_busy  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ex_is_mul) begin
          mul_start = 1'b1;
          mul_stall = 1'b1;
        end else begin
          mul_start = 1'b0;
          mul_stall = 1'b0;
        end
      end
      ST_BUSY: begin
        mul_busy = 1'b1;
        if (cnt_r != CNT_ZERO) begin
          mul_stall = 1'b1;
        end else begin
          mul_done = 1'b1;
        end
      end
      default: begin
        mul_busy = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mul_hazard_ctrl.sv
// Pipeline hazard controller: EX operand forwarding, load-use detection and
// multi-cycle MUL stall sequencing, producing stall/flush/bubble controls.
module mul_hazard_ctrl
  import mul_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MULT_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_is_mul,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  mem_reg_write,
  input  logic                  wb_reg_write,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic                  stall_front,
  output logic                  stall_ex,
  output logic                  flush_id_ex,
  output logic                  bubble_mem,
  output logic                  mul_start,
  output logic                  mul_done,
  output logic                  mul_busy
);

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};

  logic mul_stall_s;
  logic load_use_s;

  // The younger producer (EX/MEM) wins over MEM/WB; x0 is never forwarded.
  function automatic logic [1:0] fwd_pick(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] m_rd,
    input logic                  m_we,
    input logic [REG_ADDR_W-1:0] w_rd,
    input logic                  w_we
  );
    logic [1:0] sel;
    if (m_we && (m_rd != REG_ZERO) && (m_rd == rs)) begin
      sel = FWD_EXMEM;
    end else if (w_we && (w_rd != REG_ZERO) && (w_rd == rs)) begin
      sel = FWD_MEMWB;
    end else begin
      sel = FWD_REGFILE;
    end
    return sel;
  endfunction

  mul_latency_ctr #(
    .MULT_CYCLES(MULT_CYCLES)
  ) u_mul_latency_ctr (
    .clk      (clk),
    .arst_n   (arst_n),
    .ex_is_mul(ex_is_mul),
    .mul_start(mul_start),
    .mul_stall(mul_stall_s),
    .mul_done (mul_done),
    .mul_busy (mul_busy)
  );

  // Forwarding selects, load-use detection and pipeline-register controls.
  always_comb begin
    fwd_sel_a  = fwd_pick(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    fwd_sel_b  = fwd_pick(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    load_use_s = ex_mem_read && ex_reg_write && (ex_rd != REG_ZERO) &&
                 ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    if (mul_stall_s) begin
      // A MUL stall freezes ID/EX, so a pending load-use is re-checked after it ends.
      stall_front = 1'b1;
      stall_ex    = 1'b1;
      bubble_mem  = 1'b1;
      flush_id_ex = 1'b0;
    end else if (load_use_s) begin
      stall_front = 1'b1;
      stall_ex    = 1'b0;
      bubble_mem  = 1'b0;
      flush_id_ex = 1'b1;
    end else begin
      stall_front = 1'b0;
      stall_ex    = 1'b0;
      bubble_mem  = 1'b0;
      flush_id_ex = 1'b0;
    end
  end

endmodule

// File: tb/tb_mul_hazard_ctrl.sv
// Self-checking bench for mul_hazard_ctrl: directed scenarios then random traffic,
// compared against a cycle-position reference model of MUL occupancy.
module tb_mul_hazard_ctrl;

  localparam int W  = 5;
  localparam int MC = 3;

  logic         clk = 1'b0;
  logic         arst_n;
  logic [W-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic         ex_reg_write, ex_mem_read, ex_is_mul, mem_reg_write, wb_reg_write;
  logic [1:0]   fwd_sel_a, fwd_sel_b;
  logic         stall_front, stall_ex, flush_id_ex, bubble_mem;
  logic         mul_start, mul_done, mul_busy;

  int total = 0;
  int bad   = 0;
  // Model: 0 = EX not occupied by an ongoing MUL, k = k-th cycle of the MUL in EX.
  int pos   = 0;

  mul_hazard_ctrl #(.REG_ADDR_W(W), .MULT_CYCLES(MC)) dut (
    .clk(clk), .arst_n(arst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_is_mul(ex_is_mul),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall_front(stall_front),
    .stall_ex(stall_ex), .flush_id_ex(flush_id_ex), .bubble_mem(bubble_mem),
    .mul_start(mul_start), .mul_done(mul_done), .mul_busy(mul_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [W-1:0] rs);
    if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'd2;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'd1;
    return 2'd0;
  endfunction

  task automatic check_all();
    logic lu, e_start, e_done, e_busy, e_stall;
    lu      = ex_mem_read && ex_reg_write && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
    e_start = (pos == 0) && ex_is_mul;
    e_busy  = (pos != 0);
    e_done  = (pos == MC - 1);
    e_stall = e_start || (pos != 0 && pos < MC - 1);
    chk("fwd_sel_a", fwd_sel_a, ref_fwd(ex_rs1));
    chk("fwd_sel_b", fwd_sel_b, ref_fwd(ex_rs2));
    chk("mul_start", mul_start, e_start);
    chk("mul_done", mul_done, e_done);
    chk("mul_busy", mul_busy, e_busy);
    chk("stall_front", stall_front, e_stall || lu);
    chk("stall_ex", stall_ex, e_stall);
    chk("bubble_mem", bubble_mem, e_stall);
    chk("flush_id_ex", flush_id_ex, lu && !e_stall);
  endtask

  task automatic settle();
    @(negedge clk);
    check_all();
  endtask

  task automatic adv();
    @(posedge clk);
    if (pos == 0) pos = ex_is_mul ? 1 : 0;
    else if (pos == MC - 1) pos = 0;
    else pos = pos + 1;
    #1;
  endtask

  task automatic clear_inputs();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {ex_reg_write, ex_mem_read, ex_is_mul, mem_reg_write, wb_reg_write} = '0;
  endtask

  initial begin
    clear_inputs();
    arst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", mul_busy, 1'b0);
    chk("reset_stall", stall_front, 1'b0);
    settle();
    arst_n = 1'b1;
    adv();

    // 1: EX/MEM beats MEM/WB, then MEM/WB alone
    mem_rd = 5'd5; mem_reg_write = 1'b1; wb_rd = 5'd5; wb_reg_write = 1'b1; ex_rs1 = 5'd5;
    settle(); chk("t1_exmem", fwd_sel_a, 2'd2); adv();
    mem_reg_write = 1'b0;
    settle(); chk("t1_memwb", fwd_sel_a, 2'd1); adv();
    clear_inputs();

    // 2: x0 never forwards
    mem_rd = 5'd0; mem_reg_write = 1'b1; ex_rs2 = 5'd0;
    settle(); chk("t2_x0", fwd_sel_b, 2'd0); adv();
    clear_inputs();

    // 3: load-use for one cycle
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7;
    settle();
    chk("t3_front", stall_front, 1'b1); chk("t3_flush", flush_id_ex, 1'b1); chk("t3_ex", stall_ex, 1'b0);
    adv();
    clear_inputs();
    settle(); chk("t3_after", flush_id_ex, 1'b0); adv();

    // 4: MUL held, 3-cycle occupancy
    ex_is_mul = 1'b1;
    settle(); chk("t4_c0_start", mul_start, 1'b1); chk("t4_c0_stall", stall_ex, 1'b1); adv();
    settle(); chk("t4_c1_stall", stall_ex, 1'b1); chk("t4_c1_done", mul_done, 1'b0); adv();
    settle(); chk("t4_c2_done", mul_done, 1'b1); chk("t4_c2_stall", stall_ex, 1'b0); adv();
    ex_is_mul = 1'b0;
    settle(); chk("t4_c3_idle", mul_busy, 1'b0); adv();

    // 5: load-use masked by the MUL stall, then flushed once the stall ends
    ex_is_mul = 1'b1; ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9;
    settle(); chk("t5_c0_flush", flush_id_ex, 1'b0); adv();
    settle(); chk("t5_c1_flush", flush_id_ex, 1'b0); adv();
    settle(); chk("t5_c2_flush", flush_id_ex, 1'b1); chk("t5_c2_front", stall_front, 1'b1); adv();
    clear_inputs();
    settle(); adv();

    // 6: async reset mid-MUL aborts it, then a fresh MUL starts
    ex_is_mul = 1'b1;
    settle(); adv();
    #2;
    arst_n = 1'b0;
    pos    = 0;
    #1;
    chk("t6_busy", mul_busy, 1'b0);
    chk("t6_done", mul_done, 1'b0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    settle(); chk("t6_restart", mul_start, 1'b1); adv();
    clear_inputs();
    repeat (3) begin settle(); adv(); end

    // Random traffic on a small register range to provoke matches
    for (int i = 0; i < 400; i++) begin
      id_rs1 = W'($urandom_range(0, 7)); id_rs2 = W'($urandom_range(0, 7));
      ex_rs1 = W'($urandom_range(0, 7)); ex_rs2 = W'($urandom_range(0, 7));
      ex_rd  = W'($urandom_range(0, 7)); mem_rd = W'($urandom_range(0, 7));
      wb_rd  = W'($urandom_range(0, 7));
      ex_reg_write  = 1'($urandom_range(0, 1));
      ex_mem_read   = 1'($urandom_range(0, 1));
      mem_reg_write = 1'($urandom_range(0, 1));
      wb_reg_write  = 1'($urandom_range(0, 1));
      ex_is_mul     = ($urandom_range(0, 5) == 0);
      settle();
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
